adc_sample_packer: RTL and testbench

ADC_SAMPLE_PACKER -- requirements
Module: adc_sample_packer

---
 rtl/adc_sample_packer.sv | 140 ++++++++++++++
 tb/tb_adc_sample_packer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_packer.sv
// ADC sample packer: generates adc_clk, captures 8-bit samples at mid-period and
// packs them little-endian into 32-bit stream words behind a single holding register.
module adc_sample_packer #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 32
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             start,
    input  logic             stop,
    input  logic             repeat_en,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [CNT_W-1:0] sample_count,
    output logic             adc_clk,
    input  logic [7:0]       adc_data,
    output logic [31:0]      m_tdata,
    output logic [3:0]       m_tkeep,
    output logic             m_tlast,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             busy,
    output logic             overrun
);
    // state | meaning
    // IDLE  | waiting for start, adc_clk low
    // RUN   | dividing, capturing and packing samples
    // DRAIN | waiting for the final word of the pass to be accepted
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_q, div_cnt, div_src;
    logic [CNT_W-1:0] cnt_q, remain, cnt_src;
    logic             rep_q;
    logic [1:0]       byte_idx;
    logic [31:0]      part_data, packed_data, emit_data;
    logic [3:0]       keep_hi, keep_lo, emit_keep;
    logic             start_ok, tick, cap, last_smp, word_done, flush, emit, emit_last;
    logic             out_free, enter_run;

    assign busy     = (state != IDLE);
    assign start_ok = start && !stop && (sample_count != '0);
    assign tick     = (div_cnt == '0);
    assign cap      = (state == RUN) && !stop && tick && adc_clk;
    assign last_smp = (remain == CNT_W'(1));
    assign word_done = cap && ((byte_idx == 2'd3) || last_smp);
    assign flush    = (state == RUN) && stop && (byte_idx != 2'd0);
    assign emit     = word_done || flush;
    assign out_free = !m_tvalid || m_tready;

    assign packed_data = part_data | ({24'b0, adc_data} << {byte_idx, 3'b000});
    assign emit_data   = flush ? part_data : packed_data;
    // keep_hi counts the byte being captured now; keep_lo covers only bytes already held
    assign keep_hi   = {byte_idx == 2'd3, byte_idx >= 2'd2, byte_idx >= 2'd1, 1'b1};
    assign keep_lo   = {1'b0, byte_idx == 2'd3, byte_idx >= 2'd2, byte_idx >= 2'd1};
    assign emit_keep = flush ? keep_lo : keep_hi;
    assign emit_last = flush || last_smp;

    assign div_src   = (state == IDLE) ? ((clk_div == '0) ? DIV_W'(1) : clk_div) : div_q;
    assign cnt_src   = (state == IDLE) ? sample_count : cnt_q;
    assign enter_run = (state != RUN) && (state_nxt == RUN);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_ok) state_nxt = RUN;
            RUN: begin
                if (stop)                 state_nxt = (flush || !out_free) ? DRAIN : IDLE;
                else if (cap && last_smp) state_nxt = DRAIN;
            end
            DRAIN: if (out_free) state_nxt = (rep_q && !stop) ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            div_q     <= '0;
            div_cnt   <= '0;
            cnt_q     <= '0;
            remain    <= '0;
            rep_q     <= 1'b0;
            byte_idx  <= 2'd0;
            part_data <= '0;
            adc_clk   <= 1'b0;
            m_tdata   <= '0;
            m_tkeep   <= '0;
            m_tlast   <= 1'b0;
            m_tvalid  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (state == IDLE && start_ok) begin
                div_q   <= div_src;
                cnt_q   <= sample_count;
                rep_q   <= repeat_en;
                overrun <= 1'b0;
            end
            if (stop && state != IDLE) rep_q <= 1'b0;

            if (enter_run) begin
                div_cnt   <= div_src - DIV_W'(1);
                adc_clk   <= 1'b0;
                remain    <= cnt_src;
                byte_idx  <= 2'd0;
                part_data <= '0;
            end else if (state == RUN && !stop) begin
                if (tick) begin
                    adc_clk <= !adc_clk;
                    div_cnt <= div_q - DIV_W'(1);
                end else begin
                    div_cnt <= div_cnt - DIV_W'(1);
                end
                if (cap) begin
                    remain    <= remain - CNT_W'(1);
                    byte_idx  <= byte_idx + 2'd1;
                    part_data <= word_done ? '0 : packed_data;
                end
            end else begin
                adc_clk   <= 1'b0;
                byte_idx  <= 2'd0;
                part_data <= '0;
            end

            // single holding register: a word finishing while it is still occupied is lost
            if (emit && out_free) begin
                m_tvalid <= 1'b1;
                m_tdata  <= emit_data;
                m_tkeep  <= emit_keep;
                m_tlast  <= emit_last;
            end else begin
                if (m_tready) m_tvalid <= 1'b0;
                if (emit)     overrun  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_adc_sample_packer.sv
// Self-checking bench for adc_sample_packer: random ADC data, expected words
// derived from sample timing (capture k at start edge + 2*div*k) and packing rules.
module tb_adc_sample_packer;
    localparam int DIV_W = 16;
    localparam int CNT_W = 32;

    logic             aclk = 1'b0, areset = 1'b1, start = 1'b0, stop = 1'b0;
    logic             repeat_en = 1'b0, m_tready = 1'b0;
    logic [DIV_W-1:0] clk_div = '0;
    logic [CNT_W-1:0] sample_count = '0;
    logic [7:0]       adc_data = 8'h00;
    logic             adc_clk, m_tlast, m_tvalid, busy, overrun;
    logic [31:0]      m_tdata;
    logic [3:0]       m_tkeep;

    int checks = 0, errors = 0;
    int cyc = -1;
    logic [7:0]  hist[$];
    logic [31:0] rx_data[$], exp_data[$];
    logic [3:0]  rx_keep[$], exp_keep[$];
    logic        rx_last[$], exp_last[$];

    adc_sample_packer #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .aclk(aclk), .areset(areset), .start(start), .stop(stop), .repeat_en(repeat_en),
        .clk_div(clk_div), .sample_count(sample_count), .adc_clk(adc_clk), .adc_data(adc_data),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .busy(busy), .overrun(overrun)
    );

    always #5 aclk = ~aclk;

    // hist[n] is the adc_data value present at rising edge n
    always @(posedge aclk) begin
        cyc = cyc + 1;
        hist.push_back(adc_data);
        #1 adc_data = 8'($urandom);
    end

    always @(negedge aclk) begin
        if (m_tvalid && m_tready) begin
            rx_data.push_back(m_tdata);
            rx_keep.push_back(m_tkeep);
            rx_last.push_back(m_tlast);
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_cyc(input int e);
        while (cyc < e) step();
    endtask

    task automatic do_start(output int s);
        start = 1'b1;
        step();
        s = cyc;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_rx();
        rx_data.delete();
        rx_keep.delete();
        rx_last.delete();
    endtask

    // m samples actually captured out of a pass of n; pass ended early if m < n
    function automatic void build_exp(input int s, input int div, input int n, input int m);
        int nw, nb;
        logic [31:0] w;
        exp_data.delete();
        exp_keep.delete();
        exp_last.delete();
        nw = (m + 3) / 4;
        for (int j = 0; j < nw; j++) begin
            w = '0;
            nb = (m - 4 * j) < 4 ? (m - 4 * j) : 4;
            for (int b = 0; b < nb; b++) w[8 * b +: 8] = hist[s + 2 * div * (4 * j + b + 1)];
            exp_data.push_back(w);
            exp_keep.push_back(4'((1 << nb) - 1));
            exp_last.push_back((j == nw - 1) && (m == n || (m % 4) != 0));
        end
    endfunction

    task automatic test_reset();
        checks++;
        if ({adc_clk, m_tvalid, m_tlast, busy, overrun} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000", {adc_clk, m_tvalid, m_tlast, busy, overrun});
        end
        checks++;
        if ({m_tdata, m_tkeep} !== 36'h0) begin
            errors++;
            $display("FAIL reset_data: got %h/%b want 0/0000", m_tdata, m_tkeep);
        end
    endtask

    task automatic test_full_pass();
        int s;
        bit ok;
        clk_div = 3; sample_count = 256; repeat_en = 0; m_tready = 1;
        clear_rx();
        do_start(s);
        for (int j = 0; j < 24; j++) begin
            checks++;
            if (adc_clk !== (((j / 3) % 2) == 1)) begin
                errors++;
                $display("FAIL full_adc_clk edge+%0d: got %b want %b", j, adc_clk, ((j / 3) % 2) == 1);
            end
            step();
        end
        wait_idle(2000, ok);
        checks++;
        if (!ok || cyc != s + 1537) begin
            errors++;
            $display("FAIL full_busy_fall: got ok=%0d cycle %0d want cycle %0d", ok, cyc - s, 1537);
        end
        build_exp(s, 3, 256, 256);
        checks++;
        if (rx_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL full_word_count: got %0d want %0d", rx_data.size(), exp_data.size());
        end
        for (int i = 0; i < rx_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if ({rx_data[i], rx_keep[i], rx_last[i]} !== {exp_data[i], exp_keep[i], exp_last[i]}) begin
                errors++;
                $display("FAIL full_word %0d: got %h/%b/%b want %h/%b/%b", i, rx_data[i], rx_keep[i],
                         rx_last[i], exp_data[i], exp_keep[i], exp_last[i]);
            end
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL full_overrun: got %b want 0", overrun);
        end
    endtask

    task automatic test_odd_count();
        int s;
        bit ok;
        clk_div = 7; sample_count = 55; repeat_en = 0; m_tready = 1;
        clear_rx();
        do_start(s);
        wait_idle(1000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL odd_idle: got busy=%b want 0", busy);
        end
        build_exp(s, 7, 55, 55);
        checks++;
        if (rx_data.size() != 14) begin
            errors++;
            $display("FAIL odd_word_count: got %0d want 14", rx_data.size());
        end
        for (int i = 0; i < rx_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if ({rx_data[i], rx_keep[i], rx_last[i]} !== {exp_data[i], exp_keep[i], exp_last[i]}) begin
                errors++;
                $display("FAIL odd_word %0d: got %h/%b/%b want %h/%b/%b", i, rx_data[i], rx_keep[i],
                         rx_last[i], exp_data[i], exp_keep[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_stop_partial();
        int s;
        bit ok;
        clk_div = 6; sample_count = 55; repeat_en = 0; m_tready = 1;
        clear_rx();
        do_start(s);
        wait_cyc(s + 74);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle(200, ok);
        checks++;
        if (!ok || adc_clk !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle: got busy=%b adc_clk=%b want 0 0", busy, adc_clk);
        end
        build_exp(s, 6, 55, 6);
        checks++;
        if (rx_data.size() != 2) begin
            errors++;
            $display("FAIL stop_word_count: got %0d want 2", rx_data.size());
        end
        for (int i = 0; i < rx_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if ({rx_data[i], rx_keep[i], rx_last[i]} !== {exp_data[i], exp_keep[i], exp_last[i]}) begin
                errors++;
                $display("FAIL stop_word %0d: got %h/%b/%b want %h/%b/%b", i, rx_data[i], rx_keep[i],
                         rx_last[i], exp_data[i], exp_keep[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_repeat();
        int s;
        bit ok;
        clk_div = 1; sample_count = 8; repeat_en = 1; m_tready = 1;
        clear_rx();
        do_start(s);
        repeat_en = 0;
        wait_cyc(s + 500);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle(100, ok);
        checks++;
        if (!ok || adc_clk !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL repeat_idle: got busy=%b adc_clk=%b overrun=%b want 0 0 0", busy, adc_clk, overrun);
        end
        checks++;
        if (rx_data.size() < 40) begin
            errors++;
            $display("FAIL repeat_word_count: got %0d want at least 40", rx_data.size());
        end
        for (int i = 0; i < rx_data.size(); i++) begin
            checks++;
            if (i == rx_data.size() - 1 && rx_keep[i] != 4'hF) begin
                if (rx_last[i] !== 1'b1 || !(rx_keep[i] inside {4'h1, 4'h3, 4'h7})) begin
                    errors++;
                    $display("FAIL repeat_final_partial: got keep=%b last=%b want partial keep last=1",
                             rx_keep[i], rx_last[i]);
                end
            end else if ({rx_keep[i], rx_last[i]} !== {4'hF, i % 2 == 1}) begin
                errors++;
                $display("FAIL repeat_word %0d: got keep=%b last=%b want 1111 %b", i, rx_keep[i],
                         rx_last[i], i % 2 == 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int s, s2;
        bit ok;
        clk_div = 1; sample_count = 16; repeat_en = 0; m_tready = 0;
        clear_rx();
        do_start(s);
        wait_cyc(s + 9);
        build_exp(s, 1, 16, 4);
        for (int j = 0; j < 32; j++) begin
            checks++;
            if ({m_tvalid, m_tdata, m_tkeep, m_tlast} !== {1'b1, exp_data[0], 4'hF, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold edge+%0d: got %b/%h/%b/%b want 1/%h/1111/0", j + 9, m_tvalid,
                         m_tdata, m_tkeep, m_tlast, exp_data[0]);
            end
            step();
        end
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_overrun: got overrun=%b busy=%b want 1 1", overrun, busy);
        end
        m_tready = 1;
        wait_idle(20, ok);
        checks++;
        if (!ok || rx_data.size() != 1 || rx_data[0] !== exp_data[0]) begin
            errors++;
            $display("FAIL bp_release: got ok=%0d words=%0d want ok=1 words=1 data %h", ok,
                     rx_data.size(), exp_data[0]);
        end
        sample_count = 4;
        clear_rx();
        do_start(s2);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL bp_overrun_clear: got %b want 0", overrun);
        end
        wait_idle(50, ok);
        build_exp(s2, 1, 4, 4);
        checks++;
        if (!ok || rx_data.size() != 1 || {rx_data[0], rx_keep[0], rx_last[0]} !==
                {exp_data[0], exp_keep[0], exp_last[0]}) begin
            errors++;
            $display("FAIL bp_second_pass: got ok=%0d words=%0d want 1 word %h/%b/%b", ok,
                     rx_data.size(), exp_data[0], exp_keep[0], exp_last[0]);
        end
    endtask

    task automatic test_reset_midrun();
        int s;
        clk_div = 2; sample_count = 40; repeat_en = 1; m_tready = 0;
        clear_rx();
        do_start(s);
        wait_cyc(s + 20);
        checks++;
        if (m_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_valid: got %b want 1", m_tvalid);
        end
        #2 areset = 1'b1;
        #1;
        checks++;
        if ({adc_clk, m_tvalid, m_tlast, busy, overrun, m_tdata, m_tkeep} !== 41'h0) begin
            errors++;
            $display("FAIL rst_async_clear: got %b/%b/%b/%b/%b/%h/%b want all zero", adc_clk, m_tvalid,
                     m_tlast, busy, overrun, m_tdata, m_tkeep);
        end
        step();
        step();
        areset = 1'b0;
        m_tready = 1;
        repeat (100) step();
        checks++;
        if (rx_data.size() != 0 || busy !== 1'b0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_words: got words=%0d busy=%b valid=%b want 0 0 0", rx_data.size(),
                     busy, m_tvalid);
        end
    endtask

    task automatic test_ignored_starts();
        int s, dummy;
        bit ok;
        clk_div = 1; repeat_en = 0; m_tready = 1;
        clear_rx();
        sample_count = 0;
        do_start(dummy);
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_count_start: got busy=%b want 0", busy);
        end
        sample_count = 10;
        stop = 1'b1;
        do_start(dummy);
        stop = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_same: got busy=%b want 0", busy);
        end
        sample_count = 8;
        do_start(s);
        repeat (5) step();
        sample_count = 100;
        do_start(dummy);
        wait_idle(100, ok);
        checks++;
        if (!ok || rx_data.size() != 2 || rx_last[rx_data.size() - 1] !== 1'b1) begin
            errors++;
            $display("FAIL start_while_busy: got ok=%0d words=%0d want ok=1 words=2 ending tlast",
                     ok, rx_data.size());
        end
    endtask

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        test_reset();
        areset = 1'b0;
        step();
        test_reset();
        test_full_pass();
        test_odd_count();
        test_stop_partial();
        test_repeat();
        test_backpressure();
        test_reset_midrun();
        test_ignored_starts();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
